key_panel_ctrl: RTL

//  Parametrised front-panel key controller: synchronises and debounces NUM_KEYS raw keys,

---
 rtl/key_panel_ctrl.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/key_panel_ctrl.sv
// key_panel_ctrl
//   Front-panel key controller. Raw key pins are synchronised, polarity
//   normalised and debounced on a scan_tick timebase. A small per-key state
//   machine turns debounced levels into PRESS / HOLD (with auto-repeat) /
//   RELEASE events. The events are arbitrated into a first-word-fall-through
//   event FIFO.
//
// Ports
//   clk           system clock
//   reset         asynchronous active-low reset, released synchronously
//   scan_tick     one-clk strobe, timebase for debounce and hold timing
//   key_in        raw key pins (asynchronous)
//   evt_pop       consume head event; ignored while evt_valid=0
//   ovf_clr       clears evt_overflow
//   evt_valid     FIFO holds at least one event; evt_code/evt_type valid
//   evt_code      key index of head event
//   evt_type      1 PRESS, 2 HOLD, 3 RELEASE
//   evt_overflow  sticky flag, an event was dropped on a full FIFO
//   key_state     debounced key levels, 1 = pressed
module key_panel_ctrl #(
  parameter int NUM_KEYS     = 5,
  parameter int KEY_ACT_HIGH = 1,
  parameter int DEB_TICKS    = 10,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int FIFO_DEPTH   = 4,
  localparam int CODE_W      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scan_tick,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic                evt_pop,
  input  logic                ovf_clr,
  output logic                evt_valid,
  output logic [CODE_W-1:0]   evt_code,
  output logic [1:0]          evt_type,
  output logic                evt_overflow,
  output logic [NUM_KEYS-1:0] key_state
);

  localparam int DEB_W  = $clog2(DEB_TICKS + 1);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int REP_W  = $clog2(REPEAT_TICKS + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  localparam logic [1:0] EVT_PRESS   = 2'd1;
  localparam logic [1:0] EVT_HOLD    = 2'd2;
  localparam logic [1:0] EVT_RELEASE = 2'd3;

  // Idle level of the pins, so reset does not look like a press.
  localparam logic [NUM_KEYS-1:0] PIN_IDLE = (KEY_ACT_HIGH != 0) ? '0 : '1;

  logic [NUM_KEYS-1:0] sync_p0;
  logic [NUM_KEYS-1:0] sync_p1;
  logic [NUM_KEYS-1:0] norm_p1;
  logic [NUM_KEYS-1:0] key_state_d;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] fall;

  logic [DEB_W-1:0]    deb_cnt  [NUM_KEYS];
  logic [HOLD_W-1:0]   hold_cnt [NUM_KEYS];
  logic [REP_W-1:0]    rep_cnt  [NUM_KEYS];
  logic [1:0]          state    [NUM_KEYS];

  // Pending flags per key: bit0 PRESS, bit1 HOLD, bit2 RELEASE.
  logic [NUM_KEYS-1:0][2:0] pend;
  logic [NUM_KEYS-1:0][2:0] pend_set;
  logic [NUM_KEYS-1:0][2:0] pend_clr;

  logic                arb_vld;
  logic [CODE_W-1:0]   arb_code;
  logic [1:0]          arb_type;

  logic [CODE_W+1:0]   mem [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr;
  logic [PTR_W:0]      rd_ptr;
  logic [PTR_W:0]      wr_next;
  logic [PTR_W:0]      rd_next;
  logic                fifo_full;
  logic                pop;
  logic                push;
  logic                drop;
  logic                head_vld;
  logic [CODE_W+1:0]   head_data;
  logic [CODE_W+1:0]   push_data;

  // Stage p0/p1: two-flop synchroniser, then polarity normalisation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= PIN_IDLE;
      sync_p1 <= PIN_IDLE;
    end else begin
      sync_p0 <= key_in;
      sync_p1 <= sync_p0;
    end
  end

  assign norm_p1 = (KEY_ACT_HIGH != 0) ? sync_p1 : ~sync_p1;

  // Stage: debounced level edges feed the per-key FSMs one clk later
  assign rise = key_state & ~key_state_d;
  assign fall = ~key_state & key_state_d;

  always_comb begin
    pend_set = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (rise[k]) begin
        pend_set[k][0] = 1'b1;
      end else if (fall[k]) begin
        pend_set[k][2] = 1'b1;
      end else if (scan_tick) begin
        if (state[k] == ST_PRESSED && hold_cnt[k] == HOLD_W'(HOLD_TICKS - 1))
          pend_set[k][1] = 1'b1;
        if (state[k] == ST_HOLD && rep_cnt[k] == REP_W'(REPEAT_TICKS - 1))
          pend_set[k][1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_state   <= '0;
      key_state_d <= '0;
      pend        <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        deb_cnt[k]  <= '0;
        hold_cnt[k] <= '0;
        rep_cnt[k]  <= '0;
        state[k]    <= ST_IDLE;
      end
    end else begin
      key_state_d <= key_state;
      // A flag set and arbitrated in the same clk stays set: the new event wins.
      pend        <= (pend & ~pend_clr) | pend_set;
      for (int k = 0; k < NUM_KEYS; k++) begin
        // Counter reaching DEB_TICKS flips the level on the following clk.
        if (deb_cnt[k] == DEB_W'(DEB_TICKS)) begin
          key_state[k] <= ~key_state[k];
          deb_cnt[k]   <= '0;
        end else if (scan_tick) begin
          if (norm_p1[k] != key_state[k])
            deb_cnt[k] <= deb_cnt[k] + 1'b1;
          else
            deb_cnt[k] <= '0;
        end

        if (rise[k]) begin
          state[k]    <= ST_PRESSED;
          hold_cnt[k] <= '0;
        end else if (fall[k]) begin
          state[k]    <= ST_IDLE;
        end else if (scan_tick) begin
          case (state[k])
            ST_PRESSED: begin
              if (pend_set[k][1]) begin
                state[k]   <= ST_HOLD;
                rep_cnt[k] <= '0;
              end else if (hold_cnt[k] != HOLD_W'(HOLD_TICKS)) begin
                hold_cnt[k] <= hold_cnt[k] + 1'b1;
              end
            end
            ST_HOLD: begin
              if (pend_set[k][1])
                rep_cnt[k] <= '0;
              else if (rep_cnt[k] != REP_W'(REPEAT_TICKS))
                rep_cnt[k] <= rep_cnt[k] + 1'b1;
            end
            default: state[k] <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Stage: arbiter, lowest key first, PRESS > HOLD > RELEASE within a key
  always_comb begin
    arb_vld  = 1'b0;
    arb_code = '0;
    arb_type = 2'd0;
    pend_clr = '0;
    // Walk downwards so the lowest pending key is the last one to win.
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (|pend[k]) begin
        arb_vld  = 1'b1;
        arb_code = CODE_W'(k);
        pend_clr = '0;
        if (pend[k][0]) begin
          arb_type       = EVT_PRESS;
          pend_clr[k][0] = 1'b1;
        end else if (pend[k][1]) begin
          arb_type       = EVT_HOLD;
          pend_clr[k][1] = 1'b1;
        end else begin
          arb_type       = EVT_RELEASE;
          pend_clr[k][2] = 1'b1;
        end
      end
    end
  end

  // Stage: event FIFO, first-word-fall-through with registered head outputs
  assign fifo_full = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop       = evt_pop & evt_valid;
  assign push      = arb_vld & (~fifo_full | pop);
  assign drop      = arb_vld & fifo_full & ~pop;
  assign push_data = {arb_type, arb_code};
  assign wr_next   = wr_ptr + (PTR_W + 1)'(push);
  assign rd_next   = rd_ptr + (PTR_W + 1)'(pop);

  // The head written this clk is not yet in mem, so it is bypassed.
  always_comb begin
    head_vld  = (rd_next != wr_next);
    head_data = '0;
    if (head_vld) begin
      if (push && (rd_next == wr_ptr))
        head_data = push_data;
      else
        head_data = mem[rd_next[PTR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      evt_valid    <= 1'b0;
      evt_code     <= '0;
      evt_type     <= 2'd0;
      evt_overflow <= 1'b0;
    end else begin
      wr_ptr                 <= wr_next;
      rd_ptr                 <= rd_next;
      evt_valid              <= head_vld;
      {evt_type, evt_code}   <= head_data;
      // A new drop outranks a clear in the same clk.
      if (drop)
        evt_overflow <= 1'b1;
      else if (ovf_clr)
        evt_overflow <= 1'b0;
    end
  end

endmodule
